// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } div_state_e;

  // Bit-counter width able to hold the value `width`.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
interface iter_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra bit above the partial remainder holds the sign of the trial difference.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, dvs_i};
    q_o     = ~diff[WIDTH+1];
    rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned divider: restoring division on magnitudes, then sign fix-up.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           reset,
  iter_divider_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude shifts out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] orig_q, orig_d;  // raw dividend, returned as remainder on divide-by-zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  function automatic logic [WIDTH-1:0] mag(logic is_signed, logic [WIDTH-1:0] x);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state and datapath updates for the IDLE/RUN/FIX/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    orig_d    = orig_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d   = StRun;
          cnt_d     = '0;
          rem_d     = '0;
          dvd_d     = mag(bus.is_signed, bus.dividend);
          dvs_d     = mag(bus.is_signed, bus.divisor);
          orig_d    = bus.dividend;
          neg_quo_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d = bus.is_signed & bus.dividend[WIDTH-1];
        end
      end
      StRun: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        if (dvs_q == '0) begin
          quo_d = '1;
          rmd_d = orig_q;
        end else begin
          quo_d = neg_quo_q ? -dvd_q : dvd_q;
          rmd_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      orig_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      orig_q    <= orig_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
    end
  end

  assign bus.busy      = (state_q == StRun) || (state_q == StFix);
  assign bus.done      = (state_q == StDone);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: behavioural reference model plus directed and random stimulus.
module tb_iter_divider;
  import div_pkg::*;

  localparam int unsigned W   = DIV_WIDTH;
  localparam int          LAT = W + 2;  // samples from start to the done sample

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  int          phase  = 0;  // 0 idle, 1..LAT-1 busy, LAT done
  logic [31:0] exp_q  = '0;
  logic [31:0] exp_r  = '0;
  logic [31:0] pend_q = '0;
  logic [31:0] pend_r = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  // Truncating division from plain integer arithmetic.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Reference model: accept start when idle or done, results appear on the done sample.
  always @(posedge clk) begin
    if (reset) begin
      phase = 0;
      exp_q = '0;
      exp_r = '0;
    end else if ((phase == 0 || phase == LAT) && bus.start) begin
      phase = 1;
      ref_div(bus.is_signed, bus.dividend, bus.divisor, pend_q, pend_r);
    end else if (phase == LAT) begin
      phase = 0;
    end else if (phase != 0) begin
      phase++;
      if (phase == LAT) begin
        exp_q = pend_q;
        exp_r = pend_r;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, bus.busy}, {31'b0, (phase >= 1 && phase < LAT)});
      chk("done", {31'b0, bus.done}, {31'b0, (phase == LAT)});
      chk("quotient", bus.quotient, exp_q);
      chk("remainder", bus.remainder, exp_r);
    end
  end

  task automatic drive(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  // Called at the negedge where start was driven; returns at the done sample.
  task automatic wait_done(output int n, output int nbusy);
    n     = 1;
    nbusy = 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && n < 4 * LAT) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int          n;
    int          nb;
    logic [31:0] mq;
    logic [31:0] mr;
    ref_div(s, a, b, mq, mr);
    chk({name, " model q"}, mq, eq);
    chk({name, " model r"}, mr, er);
    drive(s, a, b);
    wait_done(n, nb);
    chk({name, " latency"}, n, LAT);
    chk({name, " busy cycles"}, nb, LAT - 1);
    chk({name, " q"}, bus.quotient, eq);
    chk({name, " r"}, bus.remainder, er);
  endtask

  function automatic logic [31:0] pick_dvd();
    case ($urandom_range(5))
      0:       return 32'h8000_0000;
      1:       return $urandom_range(255);
      2:       return -$urandom_range(255);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_dvs();
    case ($urandom_range(9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4, 5:    return $urandom_range(1, 15);
      6:       return -$urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nb;
    int ndone;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset q", bus.quotient, 32'd0);
    chk("reset r", bus.remainder, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("u fff9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
    run_op("u 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_op("s 5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_op("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("s -9/0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);

    // Start pulsed mid-operation must be ignored.
    drive(1'b0, 32'd1000, 32'd10);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    drive(1'b0, 32'd77, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    n = 11;
    while (!bus.done && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("ignored start latency", n, LAT);
    chk("ignored start q", bus.quotient, 32'd100);
    chk("ignored start r", bus.remainder, 32'd0);
    ndone = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("ignored start no extra done", ndone, 0);

    // Back-to-back: start held in the DONE cycle.
    run_op("u 50/6", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2);
    drive(1'b0, 32'd9, 32'd3);
    wait_done(n, nb);
    chk("b2b latency", n, LAT);
    chk("b2b q", bus.quotient, 32'd3);
    chk("b2b r", bus.remainder, 32'd0);

    // Reset in the middle of an operation.
    drive(1'b0, 32'd123, 32'd4);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", {31'b0, bus.busy}, 32'd0);
    chk("midreset done", {31'b0, bus.done}, 32'd0);
    chk("midreset q", bus.quotient, 32'd0);
    chk("midreset r", bus.remainder, 32'd0);
    ndone = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midreset no done", ndone, 0);

    // Reset and start on the same edge: reset wins.
    reset = 1'b1;
    drive(1'b0, 32'd20, 32'd4);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("reset+start busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("reset+start still idle", {31'b0, bus.busy}, 32'd0);

    // Random traffic, including starts while busy and rare resets.
    for (int i = 0; i < 45000; i++) begin
      bus.start     = ($urandom_range(3) != 0);
      bus.is_signed = $urandom_range(1);
      bus.dividend  = pick_dvd();
      bus.divisor   = pick_dvs();
      reset         = ($urandom_range(4000) == 0);
      @(negedge clk);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
